// File: rtl/r_resp_id_restorer.sv
// r_resp_id_restorer: restores original R IDs via allocator lookup, frees unique IDs on RLAST, forwards beats through a 2-entry skid buffer
// Ports: s_r* slave R channel carrying unique IDs; m_r* upstream R channel carrying original IDs;
//   unique_id_to_free/restored_id combinational allocator lookup; free_req one-cycle release strobe on each accepted RLAST.
// rst is synchronous active-low. Define R_RESP_STATS_EN to add beat_cnt, burst_cnt and err_cnt outputs.
module r_resp_id_restorer #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [RESP_WIDTH-1:0] s_rresp,
  input  logic                  s_rlast,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [ID_WIDTH-1:0]   m_rid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [RESP_WIDTH-1:0] m_rresp,
  output logic                  m_rlast,
  output logic                  free_req,
  output logic [ID_WIDTH-1:0]   unique_id_to_free,
  input  logic [ID_WIDTH-1:0]   restored_id
`ifdef R_RESP_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           burst_cnt,
  output logic [15:0]           err_cnt
`endif
);
  localparam int W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;
  logic         r_main_valid, r_skid_valid;
  logic [W-1:0] r_main, r_skid;
  logic         w_acc;
  logic [W-1:0] w_beat;
  // ready depends only on skid occupancy, so m_rready never reaches s_rready combinationally
  assign s_rready          = rst & ~r_skid_valid;
  assign w_acc             = s_rvalid & s_rready;
  assign w_beat            = {restored_id, s_rdata, s_rresp, s_rlast};
  assign unique_id_to_free = s_rid;
  // lookup and free share the cycle: the allocator returns the entry before unbinding it
  assign free_req          = w_acc & s_rlast;
  assign m_rvalid          = r_main_valid;
  assign {m_rid, m_rdata, m_rresp, m_rlast} = r_main;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (!r_main_valid || m_rready) begin
      // main is free this cycle: the older skid beat wins over a new one (skid full implies no accept)
      r_main_valid <= r_skid_valid | w_acc;
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (w_acc) begin
        r_main <= w_beat;
      end
    end else if (w_acc) begin
      r_skid       <= w_beat;
      r_skid_valid <= 1'b1;
    end
  end
`ifdef R_RESP_STATS_EN
  logic w_mhs;
  assign w_mhs = r_main_valid & m_rready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (w_mhs) beat_cnt <= beat_cnt + 32'd1;
      if (free_req) burst_cnt <= burst_cnt + 32'd1;
      if (w_mhs && m_rresp != '0) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif
endmodule
